// File: rtl/ysyx_2022040010_mem_arb.sv
// ysyx_2022040010_mem_arb: arbitrates icache refill, dcache write-back/refill and
// uncache single-beat MMIO onto one burst memory bus and sequences the transaction.
// Ports:
//   clk, rst (async, active-low)
//   ic_*  : icache line refill (read only)
//   dc_*  : dcache line write-back (dc_we=1) or refill (dc_we=0)
//   uc_*  : uncache single-beat access with byte strobes
//   rdata : registered read beat shared by all requesters
//   bus_* : address phase, write beats, read beats and write response
// Optional feature macro: ARB_RR_EN selects round-robin arbitration instead of
// fixed dcache > uncache > icache priority.
module ysyx_2022040010_mem_arb #(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned AW         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  output logic          ic_rvalid,
  output logic          ic_done,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [63:0]   dc_wdata,
  output logic          dc_wnext,
  output logic          dc_rvalid,
  output logic          dc_done,
  input  logic          uc_req,
  input  logic          uc_we,
  input  logic [AW-1:0] uc_addr,
  input  logic [7:0]    uc_mask,
  input  logic [63:0]   uc_wdata,
  output logic          uc_rvalid,
  output logic          uc_done,
  output logic [63:0]   rdata,
  output logic          bus_avalid,
  input  logic          bus_aready,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_len,
  output logic [7:0]    bus_mask,
  output logic          bus_wvalid,
  input  logic          bus_wready,
  output logic [63:0]   bus_wdata,
  output logic          bus_wlast,
  input  logic          bus_rvalid,
  input  logic          bus_rlast,
  input  logic [63:0]   bus_rdata,
  input  logic          bus_bvalid
);

  localparam int unsigned OFF_W = $clog2(LINE_BEATS) + 3;
  localparam int unsigned LEN_W = 4;
  localparam logic [LEN_W-1:0] CACHE_LEN = LEN_W'(LINE_BEATS - 1);
  localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << OFF_W;
  localparam logic [AW-1:0] BEAT_MASK = {AW{1'b1}} << 3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_DC   = 2'd1;
  localparam logic [1:0] G_UC   = 2'd2;
  localparam logic [1:0] G_IC   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_BRESP, S_RDATA, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       mask_q, mask_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             ic_rvalid_q, ic_rvalid_d;
  logic             dc_rvalid_q, dc_rvalid_d;
  logic             uc_rvalid_q, uc_rvalid_d;
  logic [1:0]       pick;
  logic             rbeat;

  // Requester selection, evaluated only while idle.
`ifdef ARB_RR_EN
  logic [1:0] last_q, last_d;
  logic       last_wb_q, last_wb_d;

  always_comb begin
    pick = G_NONE;
    if (dc_req && !dc_we && last_wb_q) begin
      // Refill right after its own write-back keeps the pair atomic.
      pick = G_DC;
    end else begin
      case (last_q)
        G_DC:    pick = uc_req ? G_UC : ic_req ? G_IC : dc_req ? G_DC : G_NONE;
        G_UC:    pick = ic_req ? G_IC : dc_req ? G_DC : uc_req ? G_UC : G_NONE;
        default: pick = dc_req ? G_DC : uc_req ? G_UC : ic_req ? G_IC : G_NONE;
      endcase
    end
  end

  always_comb begin
    last_d    = last_q;
    last_wb_d = last_wb_q;
    if (state_q == S_IDLE && pick != G_NONE) begin
      last_d    = pick;
      last_wb_d = (pick == G_DC) && dc_we;
    end
  end

  // Pointer resets to icache so the first round starts at dcache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= G_IC;
      last_wb_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      last_wb_q <= last_wb_d;
    end
  end
`else
  always_comb begin
    pick = dc_req ? G_DC : uc_req ? G_UC : ic_req ? G_IC : G_NONE;
  end
`endif

  assign rbeat = (state_q == S_RDATA) && bus_rvalid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick != G_NONE) state_d = S_ADDR;
      S_ADDR:  if (bus_aready) state_d = we_q ? S_WDATA : S_RDATA;
      S_WDATA: if (bus_wready && cnt_q == len_q) state_d = S_BRESP;
      S_BRESP: if (bus_bvalid) state_d = S_DONE;
      S_RDATA: if (bus_rvalid && bus_rlast) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction attributes latched at grant; beat counter and read capture.
  always_comb begin
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    len_d       = len_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rdata_d     = rbeat ? bus_rdata : rdata_q;
    ic_rvalid_d = rbeat && (grant_q == G_IC);
    dc_rvalid_d = rbeat && (grant_q == G_DC);
    uc_rvalid_d = rbeat && (grant_q == G_UC);
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        grant_d = pick;
        case (pick)
          G_DC: begin
            we_d = dc_we; addr_d = dc_addr & LINE_MASK;
            len_d = CACHE_LEN; mask_d = 8'hFF;
          end
          G_UC: begin
            we_d = uc_we; addr_d = uc_addr & BEAT_MASK;
            len_d = '0; mask_d = uc_mask;
          end
          G_IC: begin
            we_d = 1'b0; addr_d = ic_addr & LINE_MASK;
            len_d = CACHE_LEN; mask_d = 8'hFF;
          end
          default: ;
        endcase
      end
      S_WDATA: if (bus_wready) cnt_d = cnt_q + LEN_W'(1);
      S_RDATA: if (bus_rvalid) cnt_d = cnt_q + LEN_W'(1);
      S_DONE:  grant_d = G_NONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q     <= G_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      uc_rvalid_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      uc_rvalid_q <= uc_rvalid_d;
    end
  end

  // State-decoded outputs; wdata is forwarded live so the owner can advance on wnext.
  always_comb begin
    bus_avalid = 1'b0;
    bus_wvalid = 1'b0;
    bus_wlast  = 1'b0;
    bus_wdata  = '0;
    dc_wnext   = 1'b0;
    ic_done    = 1'b0;
    dc_done    = 1'b0;
    uc_done    = 1'b0;
    case (state_q)
      S_ADDR: bus_avalid = 1'b1;
      S_WDATA: begin
        bus_wvalid = 1'b1;
        bus_wlast  = (cnt_q == len_q);
        bus_wdata  = (grant_q == G_DC) ? dc_wdata : uc_wdata;
        dc_wnext   = bus_wready && (grant_q == G_DC);
      end
      S_DONE: begin
        ic_done = (grant_q == G_IC);
        dc_done = (grant_q == G_DC);
        uc_done = (grant_q == G_UC);
      end
      default: ;
    endcase
  end

  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_len   = len_q;
  assign bus_mask  = mask_q;
  assign rdata     = rdata_q;
  assign ic_rvalid = ic_rvalid_q;
  assign dc_rvalid = dc_rvalid_q;
  assign uc_rvalid = uc_rvalid_q;

endmodule
